// File: rtl/regfile_bist_if.sv
// Test-master connection to the 8x8 register file: one write channel and
// two combinational read ports.
interface regfile_bist_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic [DW-1:0] busX;
  logic [DW-1:0] busY;

  modport master (output WEN, RW, busW, RX, RY, input busX, busY);
  modport slave  (input WEN, RW, busW, RX, RY, output busX, busY);
endinterface

// File: rtl/regfile_bist.sv
// Register-file self-test: writes an LFSR pattern to all registers, reads it
// back on port X then port Y, and reports pass/fail and the first failure.
module regfile_bist #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic           Clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [DW-1:0]  seed,
  regfile_bist_if.master rf,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [4:0]     err_count,
  output logic [AW-1:0]  fail_addr,
  output logic           fail_port
);

  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READX,
    S_READY,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [DW-1:0] lfsr;
  logic [DW-1:0] seed_q;

  logic          chk_c;
  logic [DW-1:0] obs_c;
  logic [DW-1:0] exp_c;
  logic          miss_c;
  logic [DW-1:0] seed_c;

  // Taps fixed for the 8-bit pattern generator
  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    return {s[DW-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1
  always_comb begin
    seed_c = (seed == '0) ? DW'(1) : seed;
  end

  // Read-back comparison; register 0 must always read zero
  always_comb begin
    chk_c  = 1'b0;
    obs_c  = '0;
    if (state == S_READX) begin
      chk_c = 1'b1;
      obs_c = rf.busX;
    end else if (state == S_READY) begin
      chk_c = 1'b1;
      obs_c = rf.busY;
    end
    exp_c  = (idx == '0) ? '0 : lfsr;
    miss_c = chk_c && (obs_c != exp_c);
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      lfsr      <= DW'(1);
      seed_q    <= '0;
      rf.WEN    <= 1'b0;
      rf.RW     <= '0;
      rf.busW   <= '0;
      rf.RX     <= '0;
      rf.RY     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
    end else if (abort) begin
      // Abort drops the run but keeps the error record for inspection
      state   <= S_IDLE;
      idx     <= '0;
      rf.WEN  <= 1'b0;
      rf.RW   <= '0;
      rf.busW <= '0;
      rf.RX   <= '0;
      rf.RY   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      if (miss_c) begin
        err_count <= err_count + 5'd1;
        if (err_count == '0) begin
          fail_addr <= idx;
          fail_port <= (state == S_READY);
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WRITE;
            idx       <= '0;
            seed_q    <= seed_c;
            lfsr      <= lfsr_step(seed_c);
            rf.WEN    <= 1'b1;
            rf.RW     <= '0;
            rf.busW   <= seed_c;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
          end
        end

        S_WRITE: begin
          if (idx == LAST) begin
            state   <= S_READX;
            idx     <= '0;
            lfsr    <= seed_q;
            rf.WEN  <= 1'b0;
            rf.RW   <= '0;
            rf.busW <= '0;
            rf.RX   <= '0;
            rf.RY   <= '0;
          end else begin
            idx     <= idx + 1'b1;
            rf.RW   <= idx + 1'b1;
            rf.busW <= lfsr;
            lfsr    <= lfsr_step(lfsr);
          end
        end

        S_READX: begin
          if (idx == LAST) begin
            state <= S_READY;
            idx   <= '0;
            lfsr  <= seed_q;
            rf.RX <= '0;
            rf.RY <= '0;
          end else begin
            idx   <= idx + 1'b1;
            rf.RX <= idx + 1'b1;
            lfsr  <= lfsr_step(lfsr);
          end
        end

        S_READY: begin
          if (idx == LAST) begin
            state <= S_DONE;
            idx   <= '0;
            rf.RY <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !miss_c;
          end else begin
            idx   <= idx + 1'b1;
            rf.RY <= idx + 1'b1;
            lfsr  <= lfsr_step(lfsr);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural register file with fault modes and a
// pattern/error model computed per run from the seed.
module tb_regfile_bist;

  logic       Clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [2:0] fail_addr;
  logic       fail_port;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_bist_if #(.DW(8), .AW(3)) rf ();

  regfile_bist #(.DW(8), .AW(3)) dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .rf        (rf),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_port (fail_port)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file: mode 0 good, 1 = r3 stuck at 0, 2 = r0 writable
  logic [7:0] regs [8];
  int         fault_mode;
  logic       rf_clr;

  always @(posedge Clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (rf.WEN) begin
      if (!(rf.RW == 3'd0 && fault_mode != 2) && !(rf.RW == 3'd3 && fault_mode == 1))
        regs[rf.RW] <= rf.busW;
    end
  end

  always_comb begin
    rf.busX = regs[rf.RX];
    rf.busY = regs[rf.RY];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"},  rf.WEN, 0);
    chk({tag, "_rw"},   rf.RW, 0);
    chk({tag, "_busw"}, rf.busW, 0);
    chk({tag, "_rx"},   rf.RX, 0);
    chk({tag, "_ry"},   rf.RY, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"},  err_count, 0);
    chk({tag, "_fadr"}, fail_addr, 0);
    chk({tag, "_fprt"}, fail_port, 0);
  endtask

  task automatic clear_rf(input int mode);
    fault_mode = mode;
    rf_clr = 1'b1;
    @(posedge Clk); #1;
    rf_clr = 1'b0;
  endtask

  // One full run; pulse_at > 0 re-asserts start so it is sampled at edge T(pulse_at)
  task automatic run_test(input logic [7:0] sd, input int mode, input int pulse_at);
    logic [7:0] p [8];
    logic [7:0] stored, want;
    int exp_err, exp_addr, exp_port, cyc, wen_cnt;

    p[0] = (sd == 8'h00) ? 8'h01 : sd;
    for (int k = 1; k < 8; k++) p[k] = nxt(p[k-1]);
    exp_err = 0; exp_addr = 0; exp_port = 0;
    for (int port = 0; port < 2; port++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 0 && mode != 2)      stored = 8'h00;
        else if (k == 3 && mode == 1) stored = 8'h00;
        else                          stored = p[k];
        want = (k == 0) ? 8'h00 : p[k];
        if (stored != want) begin
          if (exp_err == 0) begin
            exp_addr = k;
            exp_port = port;
          end
          exp_err++;
        end
      end
    end

    clear_rf(mode);
    seed = sd;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("t0_busy", busy, 1);
    chk("t0_done", done, 0);
    chk("t0_wen",  rf.WEN, 1);
    chk("t0_rw",   rf.RW, 0);
    chk("t0_busw", rf.busW, p[0]);

    cyc = 0;
    wen_cnt = 1;
    while (!done && cyc < 40) begin
      if (cyc + 1 == pulse_at) start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      cyc++;
      if (rf.WEN) wen_cnt++;
      if (cyc < 8) begin
        chk("wr_rw",   rf.RW, cyc);
        chk("wr_busw", rf.busW, p[cyc]);
      end
    end
    chk("done_latency", cyc, 24);
    chk("wen_cycles",   wen_cnt, 8);
    chk("end_busy",     busy, 0);
    chk("end_ry",       rf.RY, 0);
    chk("end_pass",     pass, (exp_err == 0) ? 1 : 0);
    chk("end_err",      err_count, exp_err);
    if (exp_err > 0) begin
      chk("fail_addr", fail_addr, exp_addr);
      chk("fail_port", fail_port, exp_port);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed = 8'h00;
    rf_clr = 1'b0;
    fault_mode = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed scenarios
    run_test(8'hA5, 0, 0);
    run_test(8'h3C, 1, 0);
    run_test(8'h5A, 2, 0);
    run_test(8'h00, 0, 0);
    run_test(8'h96, 0, 5);

    // Abort 10 cycles into a run
    clear_rf(0);
    seed = 8'h77;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge Clk); #1;
    end
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wen",  rf.WEN, 0);
    chk("abort_rw",   rf.RW, 0);
    chk("abort_rx",   rf.RX, 0);
    chk("abort_ry",   rf.RY, 0);
    chk("abort_err",  err_count, 0);

    // start together with abort must not start a run
    start = 1'b1;
    abort = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", busy, 0);
    chk("abort_wins_wen",  rf.WEN, 0);
    run_test(8'h77, 0, 0);

    // Reset in the middle of a faulty run
    clear_rf(1);
    seed = 8'h3C;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge Clk); #1;
    end
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge Clk); #1;
    rst_n = 1'b1;
    run_test(8'hC3, 0, 0);

    // Randomized runs
    for (int i = 0; i < 8; i++) begin
      run_test(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 23)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
